pipeline_ctrl: RTL and testbench
================================

PIPELINE_CTRL -- requirements
Module: pipeline_ctrl

Interface
REQ-001 Parameter DRAIN_CYCLES, default 4, meaning: advancing cycles needed to empty IF/ID..MEM/WB after fetch stops.
REQ-002 clk  input  1  pipeline clock; all state changes on rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 mem_busy  input  1  data memory wait; the whole pipeline must freeze.
REQ-005 load_use_hazard  input  1  instruction in ID depends on a load in EX.
REQ-006 branch_taken  input  1  taken branch/jump resolved in EX; its PC redirect is not gated by pc_stall.
REQ-007 halt_req  input  1  level debug halt request from the debug module.
REQ-008 resume_req  input  1  single-cycle pulse; leave halt.
REQ-009 step_req  input  1  single-cycle pulse; execute one instruction, then re-halt.
REQ-010 pc_stall  output  1  blocks the sequential PC increment.
REQ-011 stall  output  4  per pipeline register Stall; bit0 IF/ID, bit1 ID/EX, bit2 EX/MEM, bit3 MEM/WB.
REQ-012 flush  output  4  per pipeline register reset_stages (bubble insert); same bit order.
REQ-013 halted  output  1  registered; high exactly while in HALTED.
REQ-014 resume_ack  output  1  registered one-cycle pulse on the HALTED->RUN transition.

Function
REQ-015 The FSM SHALL have states RUN, DRAIN, HALTED, STEP; pc_stall, stall and flush are combinational from state and inputs.
REQ-016 Priority in RUN/DRAIN/STEP SHALL be mem_busy > branch_taken > load_use_hazard.
REQ-017 mem_busy=1 SHALL drive stall=4'b1111, pc_stall=1, flush=0; branch_taken and load_use_hazard are ignored that cycle; no state transition or counter change occurs.
REQ-018 branch_taken (no mem_busy) SHALL drive flush=4'b0011, stall=0.
REQ-019 load_use_hazard (no mem_busy, no branch) SHALL drive pc_stall=1, stall=4'b0001, flush=4'b0010.
REQ-020 RUN with halt_req=1 and mem_busy=0 SHALL go to DRAIN next cycle with drain counter cleared; the hazard outputs of that cycle still apply.
REQ-021 DRAIN SHALL drive pc_stall=1 and flush[0]=1 every cycle, ORed with REQ-018/019 outputs; stall[0] is forced 0 except as per REQ-017.
REQ-022 The 3-bit drain counter SHALL increment only in DRAIN cycles with mem_busy=0 and load_use_hazard=0; on reaching DRAIN_CYCLES the FSM goes to HALTED.
REQ-023 HALTED SHALL drive pc_stall=1, stall=4'b1111, flush=0, ignoring all hazard inputs.
REQ-024 HALTED with resume_req=1 SHALL go to RUN and pulse resume_ack next cycle; resume_req beats step_req when simultaneous.
REQ-025 halt_req is sampled only in RUN; if still high after resume, RUN re-enters DRAIN on the next cycle.
REQ-026 resume_req outside HALTED and step_req outside HALTED SHALL be ignored.

Reset
REQ-027 Asserting reset at any time, including mid-DRAIN or STEP, SHALL force RUN, counter=0, halted=0, resume_ack=0, and stall=flush=0, pc_stall=0 while reset is high.

Configuration
REQ-028 With DEBUG_STEP_EN defined: HALTED with step_req=1 (resume_req=0) SHALL go to STEP; STEP drives pc_stall=0, stall=0, flush=0 for one cycle (extended while mem_busy=1), then DRAIN with counter cleared, ending in HALTED.
REQ-029 Without DEBUG_STEP_EN: STEP state and step_req logic are absent; step_req is ignored.

Structure
REQ-030 Package pipeline_ctrl_pkg SHALL hold the state enum typedef, stage index constants IDX_IF_ID..IDX_MEM_WB, and default DRAIN_CYCLES.
REQ-031 One sub-module, hazard_mux, SHALL be used for the combinational priority logic of REQ-016..019; the FSM and counter stay in pipeline_ctrl.

Verification
REQ-032 RUN, load_use_hazard=1 one cycle -> pc_stall=1, stall=0001, flush=0010 that cycle; all zero next.
REQ-033 RUN, branch_taken=1 and load_use_hazard=1 together -> flush=0011, stall=0000, pc_stall=0.
REQ-034 halt_req=1 in RUN, no hazards -> DRAIN for 4 cycles with pc_stall=1, flush=0001, then halted=1 on cycle 6 after halt_req, stall=1111.
REQ-035 DRAIN with mem_busy=1 for 3 cycles at counter=2 -> stall=1111, counter holds 2; halted rises 2 advancing cycles after mem_busy drops.
REQ-036 HALTED, resume_req pulse -> resume_ack=1 for one cycle, halted=0, outputs zero; with DEBUG_STEP_EN, step_req pulse -> one cycle pc_stall=0, then 4 drain cycles, halted=1 again.
REQ-037 reset asserted mid-DRAIN (counter=3) -> outputs zero immediately, state RUN, halted=0, no HALTED entry after release.

Source files
------------

// File: rtl/pipeline_ctrl_pkg.sv
// Shared types and constants for the pipeline stall/flush/debug-halt controller.
// The STEP state exists only when DEBUG_STEP_EN is defined.
package pipeline_ctrl_pkg;

   `ifdef DEBUG_STEP_EN
   typedef enum logic [1:0] {
      ST_RUN    = 2'd0,
      ST_DRAIN  = 2'd1,
      ST_HALTED = 2'd2,
      ST_STEP   = 2'd3
   } state_t;
   `else
   typedef enum logic [1:0] {
      ST_RUN    = 2'd0,
      ST_DRAIN  = 2'd1,
      ST_HALTED = 2'd2
   } state_t;
   `endif

   // Bit positions of each pipeline register inside stall/flush
   localparam int IDX_IF_ID  = 0;
   localparam int IDX_ID_EX  = 1;
   localparam int IDX_EX_MEM = 2;
   localparam int IDX_MEM_WB = 3;

   localparam int NUM_STAGES = 4;
   localparam logic [NUM_STAGES-1:0] STAGE_ALL = 4'b1111;

   localparam int DEFAULT_DRAIN_CYCLES = 4;

endpackage

// File: rtl/pipeline_ctrl_hazard_mux.sv
// Combinational hazard priority: mem_busy freezes everything, a taken branch
// squashes IF/ID and ID/EX, a load-use hazard holds IF/ID and bubbles ID/EX.
module hazard_mux
   import pipeline_ctrl_pkg::*;
(
   input  logic                  mem_busy,
   input  logic                  branch_taken,
   input  logic                  load_use_hazard,
   output logic                  pc_stall,
   output logic [NUM_STAGES-1:0] stall,
   output logic [NUM_STAGES-1:0] flush
);

   always_comb begin
      pc_stall = 1'b0;
      stall    = '0;
      flush    = '0;
      if (mem_busy) begin
         pc_stall = 1'b1;
         stall    = STAGE_ALL;
      end else if (branch_taken) begin
         // The redirect owns the PC this cycle, so pc_stall stays low
         flush[IDX_IF_ID] = 1'b1;
         flush[IDX_ID_EX] = 1'b1;
      end else if (load_use_hazard) begin
         pc_stall         = 1'b1;
         stall[IDX_IF_ID] = 1'b1;
         flush[IDX_ID_EX] = 1'b1;
      end
   end

endmodule

// File: rtl/pipeline_ctrl.sv
// Pipeline stall/flush controller with debug halt (RUN/DRAIN/HALTED FSM).
// Define DEBUG_STEP_EN to add single-step through the STEP state.
module pipeline_ctrl
   import pipeline_ctrl_pkg::*;
#(
   parameter int DRAIN_CYCLES = DEFAULT_DRAIN_CYCLES
)
(
   input  logic       clk,
   input  logic       reset,
   input  logic       mem_busy,
   input  logic       load_use_hazard,
   input  logic       branch_taken,
   input  logic       halt_req,
   input  logic       resume_req,
   input  logic       step_req,
   output logic       pc_stall,
   output logic [3:0] stall,
   output logic [3:0] flush,
   output logic       halted,
   output logic       resume_ack
);

   localparam logic [2:0] CNT_LAST = 3'(DRAIN_CYCLES - 1);

   state_t     state;
   state_t     state_nxt;
   logic [2:0] cnt;
   logic [2:0] cnt_nxt;

   logic       hz_pc_stall;
   logic [3:0] hz_stall;
   logic [3:0] hz_flush;

   `ifndef DEBUG_STEP_EN
   logic unused_step;
   assign unused_step = step_req;
   `endif

   hazard_mux u_hazard_mux (
      .mem_busy        (mem_busy),
      .branch_taken    (branch_taken),
      .load_use_hazard (load_use_hazard),
      .pc_stall        (hz_pc_stall),
      .stall           (hz_stall),
      .flush           (hz_flush)
   );

   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      pc_stall  = 1'b0;
      stall     = '0;
      flush     = '0;

      case (state)
         ST_RUN: begin
            pc_stall = hz_pc_stall;
            stall    = hz_stall;
            flush    = hz_flush;
            if (halt_req && !mem_busy) begin
               state_nxt = ST_DRAIN;
               cnt_nxt   = '0;
            end
         end

         ST_DRAIN: begin
            if (mem_busy) begin
               pc_stall = hz_pc_stall;
               stall    = hz_stall;
               flush    = hz_flush;
            end else begin
               // Stop fetching and keep bubbling IF/ID while older work retires
               pc_stall         = 1'b1;
               stall            = hz_stall;
               stall[IDX_IF_ID] = 1'b0;
               flush            = hz_flush;
               flush[IDX_IF_ID] = 1'b1;
               if (!load_use_hazard) begin
                  cnt_nxt = cnt + 3'd1;
                  if (cnt == CNT_LAST) begin
                     state_nxt = ST_HALTED;
                  end
               end
            end
         end

         ST_HALTED: begin
            pc_stall = 1'b1;
            stall    = STAGE_ALL;
            if (resume_req) begin
               state_nxt = ST_RUN;
            end
            `ifdef DEBUG_STEP_EN
            else if (step_req) begin
               state_nxt = ST_STEP;
            end
            `endif
         end

         `ifdef DEBUG_STEP_EN
         ST_STEP: begin
            // One instruction is released; a memory wait stretches the step
            pc_stall = hz_pc_stall;
            stall    = hz_stall;
            flush    = hz_flush;
            if (!mem_busy) begin
               state_nxt = ST_DRAIN;
               cnt_nxt   = '0;
            end
         end
         `endif

         default: begin
            state_nxt = ST_RUN;
            cnt_nxt   = '0;
         end
      endcase

      if (reset) begin
         pc_stall = 1'b0;
         stall    = '0;
         flush    = '0;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state      <= ST_RUN;
         cnt        <= '0;
         halted     <= 1'b0;
         resume_ack <= 1'b0;
      end else begin
         state      <= state_nxt;
         cnt        <= cnt_nxt;
         halted     <= (state_nxt == ST_HALTED);
         resume_ack <= (state == ST_HALTED) && (state_nxt == ST_RUN);
      end
   end

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Self-checking bench for pipeline_ctrl: directed literal cases, then random
// stimulus compared every cycle against a behavioural model.
module tb_pipeline_ctrl;

   localparam int DC = 4;
   `ifdef DEBUG_STEP_EN
   localparam bit STEP_EN = 1'b1;
   `else
   localparam bit STEP_EN = 1'b0;
   `endif

   localparam int M_RUN    = 0;
   localparam int M_DRAIN  = 1;
   localparam int M_HALTED = 2;
   localparam int M_STEP   = 3;

   logic       clk = 1'b0;
   logic       reset;
   logic       mem_busy;
   logic       load_use_hazard;
   logic       branch_taken;
   logic       halt_req;
   logic       resume_req;
   logic       step_req;
   logic       pc_stall;
   logic [3:0] stall;
   logic [3:0] flush;
   logic       halted;
   logic       resume_ack;

   int checks = 0;
   int errors = 0;

   int m_mode = M_RUN;
   int m_left = 0;
   int m_next;
   bit m_halted = 1'b0;
   bit m_ack = 1'b0;

   pipeline_ctrl #(.DRAIN_CYCLES(DC)) dut (
      .clk             (clk),
      .reset           (reset),
      .mem_busy        (mem_busy),
      .load_use_hazard (load_use_hazard),
      .branch_taken    (branch_taken),
      .halt_req        (halt_req),
      .resume_req      (resume_req),
      .step_req        (step_req),
      .pc_stall        (pc_stall),
      .stall           (stall),
      .flush           (flush),
      .halted          (halted),
      .resume_ack      (resume_ack)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Model: mode plus number of advancing drain cycles still owed
   always @(posedge clk) begin
      if (reset) begin
         m_mode   = M_RUN;
         m_left   = 0;
         m_halted = 1'b0;
         m_ack    = 1'b0;
      end else begin
         m_next = m_mode;
         case (m_mode)
            M_RUN:    if (halt_req && !mem_busy) begin m_next = M_DRAIN; m_left = DC; end
            M_DRAIN:  if (!mem_busy && !load_use_hazard) begin
                         m_left = m_left - 1;
                         if (m_left == 0) m_next = M_HALTED;
                      end
            M_HALTED: if (resume_req) m_next = M_RUN;
                      else if (STEP_EN && step_req) m_next = M_STEP;
            default:  if (!mem_busy) begin m_next = M_DRAIN; m_left = DC; end
         endcase
         m_ack    = (m_mode == M_HALTED) && (m_next == M_RUN);
         m_halted = (m_next == M_HALTED);
         m_mode   = m_next;
      end
   end

   always @(negedge clk) begin : cmp
      logic       epc;
      logic [3:0] est;
      logic [3:0] efl;
      logic       eh;
      logic       ea;
      epc = 1'b0; est = 4'h0; efl = 4'h0; eh = 1'b0; ea = 1'b0;
      if (!reset) begin
         eh = m_halted;
         ea = m_ack;
         if (m_mode == M_HALTED) begin
            epc = 1'b1; est = 4'hF;
         end else if (mem_busy) begin
            epc = 1'b1; est = 4'hF;
         end else begin
            if (branch_taken) efl = 4'h3;
            else if (load_use_hazard) begin epc = 1'b1; est = 4'h1; efl = 4'h2; end
            if (m_mode == M_DRAIN) begin
               epc = 1'b1; est = 4'h0; efl = efl | 4'h1;
            end
         end
      end
      chk("cyc_pc_stall", {3'b0, pc_stall}, {3'b0, epc});
      chk("cyc_stall", stall, est);
      chk("cyc_flush", flush, efl);
      chk("cyc_halted", {3'b0, halted}, {3'b0, eh});
      chk("cyc_resume_ack", {3'b0, resume_ack}, {3'b0, ea});
   end

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic look(input string name, input logic pc, input logic [3:0] st,
                       input logic [3:0] fl, input logic h, input logic a);
      #2;
      chk({name, ".pc_stall"}, {3'b0, pc_stall}, {3'b0, pc});
      chk({name, ".stall"}, stall, st);
      chk({name, ".flush"}, flush, fl);
      chk({name, ".halted"}, {3'b0, halted}, {3'b0, h});
      chk({name, ".resume_ack"}, {3'b0, resume_ack}, {3'b0, a});
   endtask

   initial begin
      reset = 1'b1; mem_busy = 1'b0; load_use_hazard = 1'b0; branch_taken = 1'b0;
      halt_req = 1'b0; resume_req = 1'b0; step_req = 1'b0;
      look("reset", 1'b0, 4'h0, 4'h0, 1'b0, 1'b0);
      cyc(); reset = 1'b0;
      look("idle", 1'b0, 4'h0, 4'h0, 1'b0, 1'b0);

      cyc(); load_use_hazard = 1'b1;
      look("load_use", 1'b1, 4'h1, 4'h2, 1'b0, 1'b0);
      cyc(); load_use_hazard = 1'b0;
      look("load_use_after", 1'b0, 4'h0, 4'h0, 1'b0, 1'b0);
      cyc(); branch_taken = 1'b1; load_use_hazard = 1'b1;
      look("branch_over_lu", 1'b0, 4'h0, 4'h3, 1'b0, 1'b0);
      cyc(); mem_busy = 1'b1;
      look("mem_busy_wins", 1'b1, 4'hF, 4'h0, 1'b0, 1'b0);

      cyc(); mem_busy = 1'b0; branch_taken = 1'b0; load_use_hazard = 1'b0; halt_req = 1'b1;
      look("halt_run_cycle", 1'b0, 4'h0, 4'h0, 1'b0, 1'b0);
      for (int i = 0; i < DC; i++) begin
         cyc();
         look("drain", 1'b1, 4'h0, 4'h1, 1'b0, 1'b0);
      end
      cyc(); halt_req = 1'b0;
      look("halted", 1'b1, 4'hF, 4'h0, 1'b1, 1'b0);
      cyc(); branch_taken = 1'b1; load_use_hazard = 1'b1; mem_busy = 1'b1;
      look("halted_ignores", 1'b1, 4'hF, 4'h0, 1'b1, 1'b0);
      cyc(); branch_taken = 1'b0; load_use_hazard = 1'b0; mem_busy = 1'b0; step_req = 1'b1;
      look("step_req_cycle", 1'b1, 4'hF, 4'h0, 1'b1, 1'b0);
      cyc(); step_req = 1'b0;
      if (STEP_EN) begin
         look("step", 1'b0, 4'h0, 4'h0, 1'b0, 1'b0);
         for (int i = 0; i < DC; i++) begin
            cyc();
            look("step_drain", 1'b1, 4'h0, 4'h1, 1'b0, 1'b0);
         end
         cyc();
         look("step_rehalt", 1'b1, 4'hF, 4'h0, 1'b1, 1'b0);
      end else begin
         look("step_ignored", 1'b1, 4'hF, 4'h0, 1'b1, 1'b0);
      end
      cyc(); resume_req = 1'b1;
      look("resume_cycle", 1'b1, 4'hF, 4'h0, 1'b1, 1'b0);
      cyc(); resume_req = 1'b0;
      look("resumed", 1'b0, 4'h0, 4'h0, 1'b0, 1'b1);
      cyc();
      look("ack_gone", 1'b0, 4'h0, 4'h0, 1'b0, 1'b0);

      // Drain interrupted by a memory wait at count 2
      cyc(); halt_req = 1'b1;
      look("halt2_run", 1'b0, 4'h0, 4'h0, 1'b0, 1'b0);
      cyc(); halt_req = 1'b0;
      look("drain2_a", 1'b1, 4'h0, 4'h1, 1'b0, 1'b0);
      cyc();
      look("drain2_b", 1'b1, 4'h0, 4'h1, 1'b0, 1'b0);
      for (int i = 0; i < 3; i++) begin
         cyc(); mem_busy = 1'b1;
         look("drain2_frozen", 1'b1, 4'hF, 4'h0, 1'b0, 1'b0);
      end
      cyc(); mem_busy = 1'b0;
      look("drain2_c", 1'b1, 4'h0, 4'h1, 1'b0, 1'b0);
      cyc();
      look("drain2_d", 1'b1, 4'h0, 4'h1, 1'b0, 1'b0);
      cyc();
      look("halted2", 1'b1, 4'hF, 4'h0, 1'b1, 1'b0);
      cyc(); resume_req = 1'b1;
      cyc(); resume_req = 1'b0;
      look("resumed2", 1'b0, 4'h0, 4'h0, 1'b0, 1'b1);

      // Reset in the middle of a drain
      cyc(); halt_req = 1'b1;
      cyc(); halt_req = 1'b0;
      cyc();
      cyc();
      cyc();
      look("drain_cnt3", 1'b1, 4'h0, 4'h1, 1'b0, 1'b0);
      reset = 1'b1;
      look("reset_mid_drain", 1'b0, 4'h0, 4'h0, 1'b0, 1'b0);
      cyc();
      cyc(); reset = 1'b0;
      look("after_reset", 1'b0, 4'h0, 4'h0, 1'b0, 1'b0);
      for (int i = 0; i < 6; i++) begin
         cyc();
         look("no_halt_after_reset", 1'b0, 4'h0, 4'h0, 1'b0, 1'b0);
      end

      // Random phase: the per-cycle compare process does the checking
      for (int i = 0; i < 3000; i++) begin
         cyc();
         mem_busy        = ($urandom_range(0, 3) == 0);
         load_use_hazard = ($urandom_range(0, 3) == 0);
         branch_taken    = ($urandom_range(0, 4) == 0);
         halt_req        = ($urandom_range(0, 5) == 0);
         resume_req      = ($urandom_range(0, 3) == 0);
         step_req        = ($urandom_range(0, 3) == 0);
         reset           = ($urandom_range(0, 149) == 0);
      end
      cyc();
      reset = 1'b0; mem_busy = 1'b0; load_use_hazard = 1'b0; branch_taken = 1'b0;
      halt_req = 1'b0; resume_req = 1'b0; step_req = 1'b0;
      cyc();
      cyc();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
